uart_cmd_assembler: RTL

- Sits directly downstream of the UART receiver, consuming its byte/ready handshake.
- Assembles two consecutive received bytes (high byte first) into one 16-bit command for the command processor.
- Presents the command with a set/clear ready flag, reports overrun, and resynchronises via an inter-byte gap timeout so a lost byte cannot permanently misalign framing.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_cmd_assembler_gap_timer.sv | 18 +
 rtl/uart_cmd_assembler.sv | 59 +++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths, baud/gap defaults and the command assembler state type.
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int CMD_W = 16;
  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD = 19200;
  localparam int BIT_CYCLES = CLK_HZ / BAUD;
  localparam int GAP_CYCLES = 52080;
  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;
endpackage

// File: rtl/uart_cmd_assembler_gap_timer.sv
// gap_timer: loadable down-counter that stops at zero and flags expiry.
module gap_timer #(
  parameter int GAP_CYCLES = 52080,
  parameter int TMR_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);
  logic [TMR_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= TMR_W'(GAP_CYCLES);
    else if (en && cnt != '0) cnt <= cnt - TMR_W'(1);
  assign expired = cnt == '0;
endmodule

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: pairs received bytes (high first) into 16-bit commands with overrun and gap-timeout resync.
module uart_cmd_assembler
  import uart_pkg::*;
#(
  parameter int GAP_CYCLES = uart_pkg::GAP_CYCLES,
  parameter int TMR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_rdy,
  output logic              rx_clr_rdy,
  input  logic              clr_cmd_rdy,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  output logic              overrun,
  output logic              frame_err
);
  asm_state_t state;
  logic [BYTE_W-1:0] hi_byte;
  logic expired;
  logic complete;
  assign complete = state == WAIT_LO && rx_rdy;
  // Every byte seen is consumed in the same cycle, whichever state we are in.
  assign rx_clr_rdy = rst_n && rx_rdy;
  gap_timer #(.GAP_CYCLES(GAP_CYCLES), .TMR_W(TMR_W)) u_gap_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(state == WAIT_HI && rx_rdy),
    .en(state == WAIT_LO && !rx_rdy),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= WAIT_HI;
      hi_byte <= '0;
      cmd <= '0;
      cmd_rdy <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      // An ack coinciding with completion belongs to the old command.
      cmd_rdy <= complete || (cmd_rdy && !clr_cmd_rdy);
      overrun <= complete ? (overrun || (cmd_rdy && !clr_cmd_rdy)) : (overrun && !clr_cmd_rdy);
      if (state == WAIT_HI) begin
        if (rx_rdy) begin
          hi_byte <= rx_data;
          state <= WAIT_LO;
        end
      end else if (rx_rdy) begin
        cmd <= {hi_byte, rx_data};
        state <= WAIT_HI;
      end else if (expired) begin
        frame_err <= 1'b1;
        state <= WAIT_HI;
      end
    end
endmodule
